// File: rtl/matrix_alu_sequencer.sv
// Command sequencer for the matrix ALU: owns the 5x5 int8 operands A/B, issues one opcode per EXEC, returns the result.
// Optional: define MATRIX_SEQ_TIMEOUT_EN to abandon determinant waits after DET_TIMEOUT cycles.
module matrix_alu_sequencer #(
   parameter int unsigned DET_TIMEOUT = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_type,
   input  logic [2:0]   cmd_row,
   input  logic [2:0]   cmd_col,
   input  logic [7:0]   cmd_data,
   input  logic [2:0]   cmd_opcode,
   output logic         load_error,
   output logic [199:0] alu_A_flat,
   output logic [199:0] alu_B_flat,
   output logic [7:0]   alu_f,
   output logic [2:0]   alu_opcode,
   input  logic [199:0] alu_C_flat,
   input  logic         alu_overflow,
   input  logic         alu_done,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [199:0] res_C_flat,
   output logic         res_overflow,
   output logic         res_error,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   typedef enum logic [1:0] {
      CMD_CLEAR  = 2'b00,
      CMD_LOAD_A = 2'b01,
      CMD_LOAD_B = 2'b10,
      CMD_EXEC   = 2'b11
   } cmd_e;

   localparam logic [2:0] OP_NONE = 3'b000;
   localparam logic [2:0] OP_DET  = 3'b111;

   if (DET_TIMEOUT < 2 || DET_TIMEOUT > 255) begin : g_bad_det_timeout
      $error("matrix_alu_sequencer: DET_TIMEOUT must be in 2..255");
   end

   state_e         state_q, state_d;
   logic [199:0]   a_q, a_d;
   logic [199:0]   b_q, b_d;
   logic [7:0]     f_q, f_d;
   logic [2:0]     opcode_q, opcode_d;
   logic [199:0]   res_c_q, res_c_d;
   logic           res_ovf_q, res_ovf_d;
   logic           res_err_q, res_err_d;
   logic           load_err_q, load_err_d;
`ifdef MATRIX_SEQ_TIMEOUT_EN
   localparam logic [7:0] DET_LAST = 8'(DET_TIMEOUT - 1);
   logic [7:0]     cnt_q, cnt_d;
`endif

   logic           cmd_fire;
   logic           elem_in_range;
   logic [4:0]     elem_idx;
   logic [7:0]     elem_lsb;

   assign cmd_ready     = (state_q == IDLE) && !reset;
   assign cmd_fire      = cmd_valid && cmd_ready;
   assign elem_in_range = (cmd_row <= 3'd4) && (cmd_col <= 3'd4);
   // Only meaningful when in range; wraps harmlessly otherwise since no write happens.
   assign elem_idx      = 5'(cmd_row) * 5'd5 + 5'(cmd_col);
   assign elem_lsb      = {elem_idx, 3'b000};

   assign busy         = (state_q != IDLE);
   assign res_valid    = (state_q == RESP);
   assign alu_A_flat   = a_q;
   assign alu_B_flat   = b_q;
   assign alu_f        = f_q;
   assign res_C_flat   = res_c_q;
   assign res_overflow = res_ovf_q;
   assign res_error    = res_err_q;
   assign load_error   = load_err_q;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      f_d        = f_q;
      opcode_d   = opcode_q;
      res_c_d    = res_c_q;
      res_ovf_d  = res_ovf_q;
      res_err_d  = res_err_q;
      load_err_d = 1'b0;
`ifdef MATRIX_SEQ_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif
      alu_opcode = OP_NONE;

      unique case (state_q)
         IDLE: begin
            if (cmd_fire) begin
               unique case (cmd_e'(cmd_type))
                  CMD_CLEAR: begin
                     a_d = '0;
                     b_d = '0;
                  end
                  CMD_LOAD_A: begin
                     if (elem_in_range) a_d[elem_lsb +: 8] = cmd_data;
                     else               load_err_d = 1'b1;
                  end
                  CMD_LOAD_B: begin
                     if (elem_in_range) b_d[elem_lsb +: 8] = cmd_data;
                     else               load_err_d = 1'b1;
                  end
                  CMD_EXEC: begin
                     opcode_d = cmd_opcode;
                     f_d      = cmd_data;
                     if (cmd_opcode == OP_NONE) begin
                        res_c_d   = '0;
                        res_ovf_d = 1'b0;
                        res_err_d = 1'b1;
                        state_d   = RESP;
                     end else begin
                        state_d = ISSUE;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ISSUE: begin
            alu_opcode = opcode_q;
            state_d    = WAIT;
`ifdef MATRIX_SEQ_TIMEOUT_EN
            cnt_d      = '0;
`endif
         end
         WAIT: begin
            alu_opcode = opcode_q;
            if (opcode_q != OP_DET || alu_done) begin
               res_c_d   = alu_C_flat;
               res_ovf_d = alu_overflow;
               res_err_d = 1'b0;
               state_d   = RESP;
            end
`ifdef MATRIX_SEQ_TIMEOUT_EN
            // alu_done is tested first so a completion on the last allowed cycle beats the timeout.
            else if (cnt_q == DET_LAST) begin
               res_c_d   = '0;
               res_ovf_d = 1'b0;
               res_err_d = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         RESP: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         f_q        <= '0;
         opcode_q   <= '0;
         res_c_q    <= '0;
         res_ovf_q  <= 1'b0;
         res_err_q  <= 1'b0;
         load_err_q <= 1'b0;
`ifdef MATRIX_SEQ_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         f_q        <= f_d;
         opcode_q   <= opcode_d;
         res_c_q    <= res_c_d;
         res_ovf_q  <= res_ovf_d;
         res_err_q  <= res_err_d;
         load_err_q <= load_err_d;
`ifdef MATRIX_SEQ_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// Randomized bench for matrix_alu_sequencer: matrix arrays as reference, a registered ALU stand-in, cycle-exact handshake checks.
module tb_matrix_alu_sequencer;

   localparam int unsigned DET_T = 4;

   logic         clock;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_type;
   logic [2:0]   cmd_row;
   logic [2:0]   cmd_col;
   logic [7:0]   cmd_data;
   logic [2:0]   cmd_opcode;
   logic         load_error;
   logic [199:0] alu_A_flat;
   logic [199:0] alu_B_flat;
   logic [7:0]   alu_f;
   logic [2:0]   alu_opcode;
   logic [199:0] alu_C_flat;
   logic         alu_overflow;
   logic         alu_done;
   logic         res_valid;
   logic         res_ready;
   logic [199:0] res_C_flat;
   logic         res_overflow;
   logic         res_error;
   logic         busy;

   int unsigned  n_checks = 0;
   int unsigned  n_errors = 0;
   logic [7:0]   ref_a [25];
   logic [7:0]   ref_b [25];
   int unsigned  det_delay = 0;
   int unsigned  det_cnt = 0;

   matrix_alu_sequencer #(.DET_TIMEOUT(DET_T)) dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_type     (cmd_type),
      .cmd_row      (cmd_row),
      .cmd_col      (cmd_col),
      .cmd_data     (cmd_data),
      .cmd_opcode   (cmd_opcode),
      .load_error   (load_error),
      .alu_A_flat   (alu_A_flat),
      .alu_B_flat   (alu_B_flat),
      .alu_f        (alu_f),
      .alu_opcode   (alu_opcode),
      .alu_C_flat   (alu_C_flat),
      .alu_overflow (alu_overflow),
      .alu_done     (alu_done),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_C_flat   (res_C_flat),
      .res_overflow (res_overflow),
      .res_error    (res_error),
      .busy         (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [199:0] pack(input logic [7:0] m [25]);
      logic [199:0] v;
      v = '0;
      for (int e = 0; e < 25; e++) v = v | (200'(m[e]) << (8 * e));
      return v;
   endfunction

   // Elementwise stand-in ALU: bit 200 is overflow, bits 199:0 the result matrix.
   function automatic logic [200:0] alu_fn(input logic [2:0] op, input logic [199:0] a,
                                           input logic [199:0] b, input logic [7:0] f);
      logic [200:0] r;
      int x, y, s;
      r = '0;
      for (int e = 0; e < 25; e++) begin
         x = int'($signed(8'(a >> (8 * e))));
         y = int'($signed(8'(b >> (8 * e))));
         case (op)
            3'b001:  s = x + y;
            3'b010:  s = x - y;
            3'b011:  s = x * int'($signed(f));
            default: s = x ^ y;
         endcase
         r = r | (201'(s[7:0]) << (8 * e));
         if (s < -128 || s > 127) r[200] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [200:0] noise();
      logic [200:0] v;
      for (int i = 0; i < 201; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   // Registered ALU: samples the opcode each edge, emits garbage when idle so mistimed captures show up.
   always @(posedge clock) begin
      if (alu_opcode != 3'b000) {alu_overflow, alu_C_flat} <= alu_fn(alu_opcode, alu_A_flat, alu_B_flat, alu_f);
      else                      {alu_overflow, alu_C_flat} <= noise();
      det_cnt <= (alu_opcode == 3'b111) ? det_cnt + 1 : 0;
   end

   assign alu_done = (alu_opcode == 3'b111) && (det_delay != 0) && (det_cnt == det_delay);

   task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_ref();
      for (int e = 0; e < 25; e++) begin
         ref_a[e] = 8'h00;
         ref_b[e] = 8'h00;
      end
   endtask

   task automatic issue_cmd(input logic [1:0] t, input logic [2:0] r, input logic [2:0] c,
                            input logic [7:0] d, input logic [2:0] op);
      check("cmd_ready_before_cmd", cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_type   = t;
      cmd_row    = r;
      cmd_col    = c;
      cmd_data   = d;
      cmd_opcode = op;
      step();
      cmd_valid  = 1'b0;
   endtask

   task automatic do_clear();
      issue_cmd(2'b00, 3'd0, 3'd0, 8'h00, 3'b000);
      clear_ref();
      check("clear_A", alu_A_flat, pack(ref_a));
      check("clear_B", alu_B_flat, pack(ref_b));
   endtask

   task automatic do_load(input bit to_b, input logic [2:0] r, input logic [2:0] c, input logic [7:0] d);
      bit oor;
      oor = (r > 3'd4) || (c > 3'd4);
      issue_cmd(to_b ? 2'b10 : 2'b01, r, c, d, 3'b000);
      if (!oor) begin
         if (to_b) ref_b[5 * r + c] = d;
         else      ref_a[5 * r + c] = d;
      end
      check("load_error", load_error, oor);
      check("load_A", alu_A_flat, pack(ref_a));
      check("load_B", alu_B_flat, pack(ref_b));
      check("load_no_res_valid", res_valid, 0);
   endtask

   task automatic do_exec(input logic [2:0] op, input logic [7:0] d, input int unsigned delay,
                          input int unsigned hold, input bit early_rdy);
      logic [200:0] fn;
      logic [199:0] exp_c;
      logic         exp_ovf, exp_err;
      int unsigned  waits;
      bit           timed_out;
      timed_out = 1'b0;
      det_delay = delay;
      if (op == 3'b111) begin
`ifdef MATRIX_SEQ_TIMEOUT_EN
         timed_out = (delay == 0) || (delay > DET_T);
         waits     = timed_out ? DET_T : delay;
`else
         waits     = delay;
`endif
      end else begin
         waits = 1;
      end
      fn = alu_fn(op, pack(ref_a), pack(ref_b), d);
      if (op == 3'b000 || timed_out) begin
         exp_c = '0; exp_ovf = 1'b0; exp_err = 1'b1;
      end else begin
         exp_c = fn[199:0]; exp_ovf = fn[200]; exp_err = 1'b0;
      end

      res_ready = early_rdy;
      issue_cmd(2'b11, 3'd0, 3'd0, d, op);
      check("alu_f_latched", alu_f, d);
      if (op != 3'b000) begin
         check("issue_opcode", alu_opcode, op);
         check("issue_no_valid", res_valid, 0);
         check("issue_busy", busy, 1);
         check("issue_cmd_ready", cmd_ready, 0);
         step();
         for (int unsigned i = 0; i < waits; i++) begin
            check("wait_opcode", alu_opcode, op);
            check("wait_no_valid", res_valid, 0);
            step();
         end
      end
      check("resp_valid_on_time", res_valid, 1);
      for (int i = 0; i < 300 && !res_valid; i++) step();
      if (!res_valid) begin
         $display("FAIL resp_never: got res_valid=0 expected 1 within 300 cycles");
         $fatal(1);
      end
      check("resp_opcode_zero", alu_opcode, 0);
      check("resp_C", res_C_flat, exp_c);
      check("resp_overflow", res_overflow, exp_ovf);
      check("resp_error", res_error, exp_err);
      check("resp_busy", busy, 1);
      check("resp_cmd_ready", cmd_ready, 0);
      if (!early_rdy) begin
         for (int unsigned i = 0; i < hold; i++) begin
            step();
            check("hold_valid", res_valid, 1);
            check("hold_C", res_C_flat, exp_c);
            check("hold_error", res_error, exp_err);
            check("hold_cmd_ready", cmd_ready, 0);
         end
         res_ready = 1'b1;
      end
      step();
      res_ready = 1'b0;
      check("done_valid", res_valid, 0);
      check("done_busy", busy, 0);
      check("done_cmd_ready", cmd_ready, 1);
      check("done_opcode", alu_opcode, 0);
   endtask

   initial begin
      logic [2:0]  op;
      int unsigned hold;
      int unsigned delay;
      bit          early;

      reset = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_row = '0; cmd_col = '0;
      cmd_data = '0; cmd_opcode = '0; res_ready = 1'b0;
      clear_ref();
      repeat (3) step();
      check("rst_A", alu_A_flat, 0);
      check("rst_B", alu_B_flat, 0);
      check("rst_f", alu_f, 0);
      check("rst_opcode", alu_opcode, 0);
      check("rst_res_C", res_C_flat, 0);
      check("rst_res_ovf", res_overflow, 0);
      check("rst_res_err", res_error, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_load_error", load_error, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      reset = 1'b0;
      #1;
      check("cmd_ready_after_rst", cmd_ready, 1);

      do_load(1'b0, 3'd1, 3'd2, 8'h05);
      check("A_1_2_bits", alu_A_flat[63:56], 8'h05);
      do_load(1'b1, 3'd5, 3'd0, 8'h7f);
      check("oor_cmd_ready", cmd_ready, 1);
      step();
      check("load_error_one_cycle", load_error, 0);

      do_clear();
      do_load(1'b0, 3'd0, 3'd0, 8'h03);
      do_load(1'b1, 3'd0, 3'd0, 8'h04);
      do_exec(3'b001, 8'h00, 0, 0, 1'b1);
      do_exec(3'b000, 8'h12, 0, 5, 1'b0);
      do_load(1'b0, 3'd4, 3'd4, 8'h80);
      do_load(1'b1, 3'd4, 3'd4, 8'hff);
      do_exec(3'b010, 8'h00, 0, 2, 1'b0);
      do_exec(3'b111, 8'h00, 10, 0, 1'b1);
      do_exec(3'b111, 8'h00, 1, 1, 1'b0);
`ifdef MATRIX_SEQ_TIMEOUT_EN
      do_exec(3'b111, 8'h00, 0, 1, 1'b0);
      do_exec(3'b111, 8'h00, DET_T, 0, 1'b1);
      do_exec(3'b111, 8'h00, DET_T + 1, 0, 1'b1);
`endif

      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 7) == 0) do_clear();
         repeat ($urandom_range(1, 4))
            do_load(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)), 8'($urandom));
         op    = 3'($urandom_range(0, 7));
         hold  = $urandom_range(0, 3);
         early = (hold == 0) && ($urandom_range(0, 1) == 1);
         delay = (op == 3'b111) ? $urandom_range(1, DET_T + 1) : 0;
         do_exec(op, 8'($urandom), delay, hold, early);
      end

      do_load(1'b0, 3'd2, 3'd3, 8'h5a);
      do_load(1'b1, 3'd3, 3'd2, 8'ha5);
      det_delay = 0;
      issue_cmd(2'b11, 3'd0, 3'd0, 8'h33, 3'b111);
      step();
      step();
      step();
      check("pre_reset_opcode", alu_opcode, 3'b111);
      check("pre_reset_no_valid", res_valid, 0);
      reset = 1'b1;
      step();
      clear_ref();
      check("midrst_opcode", alu_opcode, 0);
      check("midrst_valid", res_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_A", alu_A_flat, pack(ref_a));
      check("midrst_B", alu_B_flat, pack(ref_b));
      check("midrst_f", alu_f, 0);
      check("midrst_cmd_ready", cmd_ready, 0);
      reset = 1'b0;
      step();
      check("post_rst_valid", res_valid, 0);
      check("post_rst_cmd_ready", cmd_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/matrix_alu_sequencer.md
# matrix_alu_sequencer

Command-driven controller that owns the 5x5 signed-8-bit matrix operand registers of the arithmetic coprocessor and sequences the matrix ALU. It accepts load and execute commands through a valid/ready handshake and issues a single opcode to the ALU. It waits for the registered result, or for `alu_done` on a determinant, then returns the 200-bit result and flags through a second valid/ready handshake. It sits between the host/bus interface and the `alu` instance.

## Interface
- `DET_TIMEOUT`, 64: cycles to wait for `alu_done` on opcode 3'b111; used only with `MATRIX_SEQ_TIMEOUT_EN`; legal range 2..255.

- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_type`  in  2  2'b00 CLEAR, 2'b01 LOAD_A, 2'b10 LOAD_B, 2'b11 EXEC.
- `cmd_row`, `cmd_col`  in  3 each  element coordinates for LOAD_A and LOAD_B.
- `cmd_data`  in  8  element value for LOAD_A and LOAD_B; scalar for EXEC.
- `cmd_opcode`  in  3  ALU opcode for EXEC.
- `load_error`  out  1  one-cycle pulse: LOAD with row > 4 or col > 4.
- `alu_A_flat`, `alu_B_flat`  out  200 each  operand registers.
- `alu_f`  out  8  latched scalar.
- `alu_opcode`  out  3  opcode driven to the ALU.
- `alu_C_flat`  in  200  ALU result.
- `alu_overflow`  in  1  ALU overflow flag.
- `alu_done`  in  1  ALU determinant-complete flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid && res_ready`.
- `res_C_flat`  out  200  captured result.
- `res_overflow`  out  1  captured overflow flag.
- `res_error`  out  1  invalid opcode, or determinant timeout.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Element (i,j) occupies bits `[8*(5*i+j) +: 8]` of A and of B.
- States: IDLE, ISSUE, WAIT, RESP.
- `cmd_ready` = (state == IDLE) && !reset.
- **IDLE, CLEAR:** zero A and B in one cycle; no response; remain IDLE.
- **IDLE, LOAD_A / LOAD_B:**
  - In range: write the element; no response; remain IDLE.
  - Out of range: no write; pulse `load_error`; remain IDLE.
  - Back-to-back loads complete one per cycle.
- **IDLE, EXEC:**
  - Latch `cmd_opcode` and `cmd_data` into the `alu_f` register.
  - Opcode 3'b000: skip the ALU; load `res_C_flat` = 0, `res_overflow` = 0, `res_error` = 1; go to RESP.
  - Otherwise: go to ISSUE.
- **ISSUE:** 1 cycle, `alu_opcode` = latched opcode; go to WAIT.
- **WAIT:**
  - `alu_opcode` is held at the latched opcode.
  - Opcodes 001–110: capture `alu_C_flat` and `alu_overflow` at the end of the first WAIT cycle; `res_error` = 0; go to RESP.
  - Opcode 111: stay in WAIT until `alu_done` = 1; then capture, set `res_error` = 0, and go to RESP.
- **RESP:**
  - `res_valid` = 1; result registers held stable.
  - On `res_ready`, go to IDLE.
  - `res_valid` deasserts the following cycle.
- `alu_opcode` = 3'b000 in every state except ISSUE and WAIT.
- Commands are never accepted outside IDLE; A and B are therefore stable during an operation.

## Timing
- Reset values:
  - State IDLE.
  - A and B all zero.
  - `alu_f` = 0, `alu_opcode` = 0.
  - `res_*` = 0, `res_valid` = 0.
  - `load_error` = 0, `busy` = 0, `cmd_ready` = 0.
- Reset has priority in every state. Reset mid-operation abandons the operation; no response is produced.
- LOAD and CLEAR: register updated at the accept edge; visible on `alu_A_flat` / `alu_B_flat` the next cycle.
- EXEC accepted at edge k:
  - ISSUE occupies cycle k+1 (the ALU samples the opcode at its end).
  - WAIT occupies cycle k+2.
  - `res_valid` is high from cycle k+3.
  - Latency is 3 cycles for opcodes 001–110.
- Invalid opcode: `res_valid` is high from cycle k+1.
- `res_ready` may be held high in advance; the transaction completes in the first RESP cycle.
- A new command can be accepted on the cycle after the RESP handshake.

## Configuration
- **`MATRIX_SEQ_TIMEOUT_EN` defined:**
  - An 8-bit counter runs in WAIT for opcode 111.
  - If `alu_done` is not seen within `DET_TIMEOUT` WAIT cycles, the block goes to RESP with `res_C_flat` = 0, `res_overflow` = 0, `res_error` = 1.
  - If `alu_done` arrives on the last allowed cycle, it wins.
- **Undefined:** no counter; WAIT on opcode 111 lasts until `alu_done` or `reset`.

## Test plan
- Reset, then LOAD_A (1,2,0x05) -> `alu_A_flat[63:56]` = 0x05 on the next cycle; all other bits 0; no `res_valid`.
- LOAD_B (5,0,0x7F) -> `load_error` pulses for 1 cycle; `alu_B_flat` unchanged; `cmd_ready` stays 1.
- A(0,0)=0x03, B(0,0)=0x04, EXEC opcode 001 at edge k, `res_ready`=1 -> `alu_opcode` = 001 in cycles k+1 and k+2; `res_valid` in cycle k+3 with `res_C_flat[7:0]` = 0x07 and `res_error` = 0.
- EXEC 000 -> `res_valid` next cycle with `res_error` = 1 and `alu_opcode` held at 000; then `res_ready` held low for 5 cycles -> `res_valid` and the result stay stable; `cmd_ready` = 0 throughout.
- EXEC 111 with `alu_done` raised 10 cycles into WAIT -> capture on that cycle. With `MATRIX_SEQ_TIMEOUT_EN` and `DET_TIMEOUT`=4 and `alu_done` never raised -> `res_error` = 1 after 4 WAIT cycles.
- Assert `reset` during WAIT of opcode 111 -> next cycle: IDLE, `alu_opcode` = 0, A and B zero, no `res_valid`.
